// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, default word width, record length.
// CHK only exists when PROGRAM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int REC_BYTES      = 4;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        REC    = 3'd2,
        WRITE  = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK    = 3'd4,
`endif
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

endpackage

// File: rtl/loader_byte_assembler.sv
// Collects four stream bytes into an opcode/operand pair; outputs show the assembled record
// (including the byte on byte_data) in the cycle record_complete strobes.
module loader_byte_assembler
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  record_complete
);

    localparam int REC_W = 2 * DATA_WIDTH;
    localparam int IW    = $clog2(REC_BYTES);
    localparam logic [IW-1:0] LAST = IW'(REC_BYTES - 1);

    logic [IW-1:0]    idx;
    logic [REC_W-1:0] shift;
    logic [REC_W-1:0] assembled;

    assign assembled       = {shift[REC_W-9:0], byte_data};
    assign record_complete = byte_valid && (idx == LAST);
    assign opcode          = assembled[REC_W-1 -: DATA_WIDTH];
    assign operand         = assembled[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx   <= '0;
            shift <= '0;
        end else if (byte_valid) begin
            idx   <= idx + 1'b1;
            shift <= assembled;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream of 4-byte records into instruction memory, holding the CPU
// until done. Optional trailing XOR checksum enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  start,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_opcode,
    output logic [DATA_WIDTH-1:0] imem_operand,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [16:0] MAX_N = 17'(1) << ADDR_WIDTH;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t                state;
    logic [7:0]            len_hi;
    logic [15:0]           count;
    logic                  accept;
    logic                  reload;
    logic                  rec_done;
    logic [DATA_WIDTH-1:0] asm_opcode;
    logic [DATA_WIDTH-1:0] asm_operand;
    logic [15:0]           len_n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    // Status outputs are pure decodes of the state register.
    assign in_ready   = (state == LEN_HI) || (state == LEN_LO) || (state == REC)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        || (state == CHK)
`endif
                        ;
    assign cpu_hold   = (state != DONE);
    assign load_done  = (state == DONE);
    assign load_error = (state == ERROR);

    assign accept = in_valid && in_ready;
    assign reload = start && ((state == DONE) || (state == ERROR));
    assign len_n  = {len_hi, in_data};

    loader_byte_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
        .clk             (clk),
        .reset           (reset),
        .clear           (reload),
        .byte_valid      (accept && (state == REC)),
        .byte_data       (in_data),
        .opcode          (asm_opcode),
        .operand         (asm_operand),
        .record_complete (rec_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LEN_HI;
            len_hi       <= '0;
            count        <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_opcode  <= '0;
            imem_operand <= '0;
            words_loaded <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                LEN_HI: if (accept) begin
                    len_hi <= in_data;
                    state  <= LEN_LO;
                end
                LEN_LO: if (accept) begin
                    count <= len_n;
                    if ({1'b0, len_n} > MAX_N) state <= ERROR;
                    else if (len_n == 16'd0)   state <= END_STATE;
                    else                       state <= REC;
                end
                REC: if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum <= csum ^ in_data;
`endif
                    if (rec_done) begin
                        state        <= WRITE;
                        imem_we      <= 1'b1;
                        imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                        imem_opcode  <= asm_opcode;
                        imem_operand <= asm_operand;
                    end
                end
                WRITE: begin
                    words_loaded <= words_loaded + 1'b1;
                    if ((17'(words_loaded) + 17'd1) < {1'b0, count}) state <= REC;
                    else                                              state <= END_STATE;
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                CHK: if (accept) state <= (in_data == csum) ? DONE : ERROR;
`endif
                DONE, ERROR: if (start) begin
                    state        <= LEN_HI;
                    words_loaded <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum         <= '0;
`endif
                end
                default: state <= LEN_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed corner sequences plus a table of randomized loads
// checked against a queue-based model of the stream format.
module tb_program_loader;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MAXN = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, in_valid, start;
    logic [7:0]    in_data;
    logic          in_ready, imem_we, cpu_hold, load_done, load_error;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_opcode, imem_operand;
    logic [AW:0]   words_loaded;

    program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .start(start), .imem_we(imem_we), .imem_addr(imem_addr), .imem_opcode(imem_opcode),
        .imem_operand(imem_operand), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write log and protocol watchers
    logic [31:0]   wr_q[$];
    logic [AW-1:0] wa_q[$];
    int            we_ready_viol = 0, we_long_viol = 0, stable_viol = 0;
    logic          we_prev = 1'b0, rst_prev = 1'b1;
    logic [AW+2*DW-1:0] out_prev = '0;

    always @(posedge clk) begin
        if (imem_we) begin
            wr_q.push_back({imem_opcode, imem_operand});
            wa_q.push_back(imem_addr);
            if (in_ready) we_ready_viol++;
            if (we_prev) we_long_viol++;
        end else if (!rst_prev && ({imem_addr, imem_opcode, imem_operand} !== out_prev)) begin
            stable_viol++;
        end
        we_prev  = imem_we;
        rst_prev = reset;
        out_prev = {imem_addr, imem_opcode, imem_operand};
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50; i++) begin
            bit r = in_ready;
            @(posedge clk); #1;
            if (r) begin ok = 1; break; end
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: byte 0x%0h not accepted in 50 cycles", b);
        end
    endtask

    task automatic send_rec(input logic [31:0] r, input bit gaps);
        for (int k = 3; k >= 0; k--) send_byte(r[k*8 +: 8], gaps);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; start = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_final();
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (load_done || load_error) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL final_timeout: no load_done/load_error within 2000 cycles");
        end
    endtask

    function automatic logic [7:0] xor_bytes(input logic [31:0] recs[$]);
        logic [7:0] x = '0;
        foreach (recs[i]) x ^= recs[i][31:24] ^ recs[i][23:16] ^ recs[i][15:8] ^ recs[i][7:0];
        return x;
    endfunction

    typedef struct {
        int n;
        bit gaps;
        bit bad_chk;
        bit exp_done;
        bit exp_error;
        int exp_writes;
    } vec_t;
    vec_t vecs[$];

    // One randomized load: model = "N legal -> records land at 0..N-1 in order".
    task automatic run_vec(input vec_t v, input int id);
        logic [31:0] recs[$];
        logic [7:0]  cs;
        logic [15:0] n16 = 16'(v.n);
        string t = $sformatf("vec%0d_n%0d", id, v.n);
        if (v.n <= MAXN) for (int i = 0; i < v.n; i++) recs.push_back($urandom);
        cs = xor_bytes(recs) ^ (v.bad_chk ? 8'h01 : 8'h00);
        wr_q.delete(); wa_q.delete();
        send_byte(n16[15:8], v.gaps);
        send_byte(n16[7:0], v.gaps);
        foreach (recs[i]) send_rec(recs[i], v.gaps);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (v.n <= MAXN) send_byte(cs, v.gaps);
`endif
        wait_final();
        repeat (2) begin @(posedge clk); #1; end
        check({t, "_done"}, load_done, v.exp_done);
        check({t, "_error"}, load_error, v.exp_error);
        check({t, "_hold"}, cpu_hold, !v.exp_done);
        check({t, "_nwrites"}, wr_q.size(), v.exp_writes);
        check({t, "_words"}, words_loaded, v.exp_writes);
        for (int i = 0; i < wr_q.size() && i < recs.size(); i++) begin
            check($sformatf("%s_addr%0d", t, i), wa_q[i], i % MAXN);
            check($sformatf("%s_data%0d", t, i), wr_q[i], recs[i]);
        end
    endtask

    initial begin
        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_opcode", imem_opcode, 0);
        check("rst_operand", imem_operand, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", load_done, 0);
        check("rst_error", load_error, 0);
        check("rst_words", words_loaded, 0);

        // Two records back-to-back; exact write latency and hold release timing.
        wr_q.delete(); wa_q.delete();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_rec(32'h2201_0003, 0);
        check("d1_we0", imem_we, 1);
        check("d1_addr0", imem_addr, 0);
        check("d1_op0", imem_opcode, 16'h2201);
        check("d1_opd0", imem_operand, 16'h0003);
        check("d1_ready_write", in_ready, 0);
        send_rec(32'h7100_0000, 0);
        check("d1_we1", imem_we, 1);
        check("d1_addr1", imem_addr, 1);
        check("d1_op1", imem_opcode, 16'h7100);
        check("d1_hold_in_write", cpu_hold, 1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h51, 0);
`else
        @(posedge clk); #1;
`endif
        check("d1_hold_fall", cpu_hold, 0);
        check("d1_done", load_done, 1);
        check("d1_words", words_loaded, 2);
        check("d1_nwrites", wr_q.size(), 2);
        repeat (3) begin @(posedge clk); #1; end
        check("d1_addr_hold", imem_addr, 1);
        check("d1_op_hold", imem_opcode, 16'h7100);

        // Reset mid-record: partial record dropped, count restarts.
        do_start();
        check("start_hold", cpu_hold, 1);
        check("start_words", words_loaded, 0);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        do_reset();
        wr_q.delete(); wa_q.delete();
        check("midrec_words", words_loaded, 0);
        check("midrec_ready", in_ready, 1);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_rec(32'hCAFE_BEEF, 0);
        // Reset during the WRITE cycle must discard the write's count update.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midwrite_words", words_loaded, 0);
        check("midwrite_we", imem_we, 0);
        wr_q.delete(); wa_q.delete();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_rec(32'hCAFE_BEEF, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'hCA ^ 8'hFE ^ 8'hBE ^ 8'hEF, 0);
`endif
        wait_final();
        check("rerun_nwrites", wr_q.size(), 1);
        if (wr_q.size() > 0) check("rerun_data", wr_q[0], 32'hCAFE_BEEF);
        check("rerun_words", words_loaded, 1);
        check("rerun_done", load_done, 1);

        vecs.push_back('{n: 2,    gaps: 0, bad_chk: 0, exp_done: 1, exp_error: 0, exp_writes: 2});
        vecs.push_back('{n: 0,    gaps: 0, bad_chk: 0, exp_done: 1, exp_error: 0, exp_writes: 0});
        vecs.push_back('{n: 257,  gaps: 0, bad_chk: 0, exp_done: 0, exp_error: 1, exp_writes: 0});
        vecs.push_back('{n: 6,    gaps: 1, bad_chk: 0, exp_done: 1, exp_error: 0, exp_writes: 6});
        vecs.push_back('{n: 1,    gaps: 1, bad_chk: 0, exp_done: 1, exp_error: 0, exp_writes: 1});
        vecs.push_back('{n: 256,  gaps: 0, bad_chk: 0, exp_done: 1, exp_error: 0, exp_writes: 256});
        vecs.push_back('{n: 4096, gaps: 0, bad_chk: 0, exp_done: 0, exp_error: 1, exp_writes: 0});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        vecs.push_back('{n: 3,    gaps: 1, bad_chk: 1, exp_done: 0, exp_error: 1, exp_writes: 3});
`endif
        foreach (vecs[i]) begin
            do_start();
            run_vec(vecs[i], i);
        end

        // Checksum verdict on a known record.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            do_start();
            wr_q.delete(); wa_q.delete();
            send_byte(8'h00, 0); send_byte(8'h01, 0);
            send_rec(32'h1234_5678, 0);
            send_byte(k == 0 ? 8'h08 : 8'h09, 0);
            wait_final();
            check($sformatf("chk%0d_done", k), load_done, k == 0);
            check($sformatf("chk%0d_error", k), load_error, k == 1);
            check($sformatf("chk%0d_nwrites", k), wr_q.size(), 1);
        end
`endif

        check("we_while_ready", we_ready_viol, 0);
        check("we_multi_cycle", we_long_viol, 0);
        check("imem_out_unstable", stable_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
